// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_div_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } div_state_e;

   localparam int DEF_WORD_LENGTH    = 16;
   localparam int DEF_N_BITS_COUNTER = 5;

   // Every quotient bit is set on a divide by zero.
   localparam logic DBZ_QUOTIENT_BIT = 1'b1;

endpackage

// File: rtl/seq_divider_counter.sv
// Iteration counter: synchronous clear wins over enable; terminal flags count==TERMINAL.
module div_counter #(
   parameter int NBitsForCounter = 5,
   parameter int TERMINAL        = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic sync_clear,
   output logic terminal
);

   localparam logic [NBitsForCounter-1:0] TERM_C = NBitsForCounter'(TERMINAL);

   logic [NBitsForCounter-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (sync_clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign terminal = (count_q == TERM_C);

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock; start/busy/done handshake.
// Defining SEQ_DIV_SIGNED_EN switches to two's complement operands (sign fixup in FINISH).
module seq_divider
   import seq_div_pkg::*;
#(
   parameter int WORD_LENGTH     = DEF_WORD_LENGTH,
   parameter int NBitsForCounter = DEF_N_BITS_COUNTER
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [WORD_LENGTH-1:0] dividend,
   input  logic [WORD_LENGTH-1:0] divisor,
   output logic                   busy,
   output logic                   done,
   output logic [WORD_LENGTH-1:0] quotient,
   output logic [WORD_LENGTH-1:0] remainder,
   output logic                   div_by_zero
);

   localparam int W        = WORD_LENGTH;
   localparam int ITER_END = WORD_LENGTH - 1;

   div_state_e     state_q, state_d;
   logic [W-1:0]   rem_q, rem_d;
   logic [W-1:0]   quo_q, quo_d;
   logic [W-1:0]   dsr_q, dsr_d;
   logic           dbz_q, dbz_d;
   logic [W-1:0]   quotient_q, quotient_d;
   logic [W-1:0]   remainder_q, remainder_d;
   logic           div_by_zero_q, div_by_zero_d;
   logic           done_q, done_d;
   logic           cnt_en, cnt_clear, cnt_term;
   logic [W:0]     r_shift, r_diff;

`ifdef SEQ_DIV_SIGNED_EN
   logic q_neg_q, q_neg_d, r_neg_q, r_neg_d;

   function automatic logic [W-1:0] neg_if(input logic neg, input logic [W-1:0] v);
      return neg ? (~v + 1'b1) : v;
   endfunction
`endif

   div_counter #(
      .NBitsForCounter(NBitsForCounter),
      .TERMINAL       (ITER_END)
   ) u_iter_cnt (
      .clk       (clk),
      .reset     (reset),
      .enable    (cnt_en),
      .sync_clear(cnt_clear),
      .terminal  (cnt_term)
   );

   // The stored remainder is always below the divisor, so W bits hold it; the shifted
   // value and the trial subtraction are W+1 bits, and the borrow bit is the R>=D compare.
   assign r_shift = {rem_q, quo_q[W-1]};
   assign r_diff  = r_shift - {1'b0, dsr_q};

   always_comb begin
      state_d       = state_q;
      rem_d         = rem_q;
      quo_d         = quo_q;
      dsr_d         = dsr_q;
      dbz_d         = dbz_q;
      quotient_d    = quotient_q;
      remainder_d   = remainder_q;
      div_by_zero_d = div_by_zero_q;
      done_d        = 1'b0;
      cnt_en        = 1'b0;
      cnt_clear     = 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      q_neg_d       = q_neg_q;
      r_neg_d       = r_neg_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
`ifdef SEQ_DIV_SIGNED_EN
               quo_d   = neg_if(dividend[W-1], dividend);
               dsr_d   = neg_if(divisor[W-1], divisor);
               q_neg_d = dividend[W-1] ^ divisor[W-1];
               r_neg_d = dividend[W-1];
`else
               quo_d   = dividend;
               dsr_d   = divisor;
`endif
               rem_d     = '0;
               dbz_d     = (divisor == '0);
               cnt_clear = 1'b1;
               state_d   = RUN;
            end
         end
         RUN: begin
            cnt_en = 1'b1;
            // A zero divisor spends one RUN cycle idle so done lands two edges after start.
            if (dbz_q) begin
               state_d = FINISH;
            end else begin
               if (r_diff[W]) begin
                  rem_d = r_shift[W-1:0];
                  quo_d = {quo_q[W-2:0], 1'b0};
               end else begin
                  rem_d = r_diff[W-1:0];
                  quo_d = {quo_q[W-2:0], 1'b1};
               end
               if (cnt_term) begin
                  state_d = FINISH;
               end
            end
         end
         FINISH: begin
            done_d        = 1'b1;
            div_by_zero_d = dbz_q;
            state_d       = IDLE;
`ifdef SEQ_DIV_SIGNED_EN
            if (dbz_q) begin
               quotient_d  = {W{DBZ_QUOTIENT_BIT}};
               remainder_d = neg_if(r_neg_q, quo_q);
            end else begin
               quotient_d  = neg_if(q_neg_q, quo_q);
               remainder_d = neg_if(r_neg_q, rem_q);
            end
`else
            if (dbz_q) begin
               quotient_d  = {W{DBZ_QUOTIENT_BIT}};
               remainder_d = quo_q;
            end else begin
               quotient_d  = quo_q;
               remainder_d = rem_q;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         rem_q         <= '0;
         quo_q         <= '0;
         dsr_q         <= '0;
         dbz_q         <= 1'b0;
         quotient_q    <= '0;
         remainder_q   <= '0;
         div_by_zero_q <= 1'b0;
         done_q        <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
         q_neg_q       <= 1'b0;
         r_neg_q       <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         rem_q         <= rem_d;
         quo_q         <= quo_d;
         dsr_q         <= dsr_d;
         dbz_q         <= dbz_d;
         quotient_q    <= quotient_d;
         remainder_q   <= remainder_d;
         div_by_zero_q <= div_by_zero_d;
         done_q        <= done_d;
`ifdef SEQ_DIV_SIGNED_EN
         q_neg_q       <= q_neg_d;
         r_neg_q       <= r_neg_d;
`endif
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, hand sequences, randomized ops vs model.
module tb_seq_divider;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] dividend, divisor;
   logic         busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;

   int n_checks = 0;
   int n_pass   = 0;

   logic [2*W:0] exp_q[$];

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
      int           lat;
   } vec_t;

   vec_t vt[8];

   seq_divider #(.WORD_LENGTH(W), .NBitsForCounter(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_checks++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
   endtask

   // Behavioural reference: {div_by_zero, quotient, remainder}.
   function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
      int qi, ri;
`ifdef SEQ_DIV_SIGNED_EN
      int sa, sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
`else
      int sa, sb;
      sa = int'({16'h0, a});
      sb = int'({16'h0, b});
`endif
      if (b == '0) return {1'b1, {W{1'b1}}, a};
      qi = sa / sb;
      ri = sa % sb;
      return {1'b0, qi[W-1:0], ri[W-1:0]};
   endfunction

   // One-cycle start; operands are scrambled right after acceptance.
   task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(negedge clk);
      start    = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
   endtask

   task automatic wait_done(output int lat, output logic [W-1:0] q, output logic [W-1:0] r,
                            output logic z, output int bcnt, output logic bdone);
      lat   = -1;
      bcnt  = 0;
      q     = '0;
      r     = '0;
      z     = 1'b0;
      bdone = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (done) begin
            lat   = n;
            q     = quotient;
            r     = remainder;
            z     = div_by_zero;
            bdone = busy;
            break;
         end
         if (busy) bcnt++;
      end
   endtask

   initial begin
      int           lat, bcnt, ndone;
      int           dpos[$];
      logic [W-1:0] q, r, a, b;
      logic         z, bdone;
      logic [2*W:0] exp_v;

`ifdef SEQ_DIV_SIGNED_EN
      vt[0] = '{16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 17};
      vt[1] = '{16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 17};
      vt[2] = '{16'd5,    16'd0,    16'hFFFF, 16'd5,    1'b1, 2};
      vt[3] = '{16'hFFF9, 16'h0000, 16'hFFFF, 16'hFFF9, 1'b1, 2};
      vt[4] = '{16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 17};
      vt[5] = '{16'd7,    16'hFFFE, 16'hFFFD, 16'd1,    1'b0, 17};
      vt[6] = '{16'hFFF9, 16'hFFFE, 16'd3,    16'hFFFF, 1'b0, 17};
      vt[7] = '{16'd1234, 16'd1234, 16'd1,    16'd0,    1'b0, 17};
`else
      vt[0] = '{16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 17};
      vt[1] = '{16'hFFFF, 16'h8001, 16'd1,    16'h7FFE, 1'b0, 17};
      vt[2] = '{16'd5,    16'd0,    16'hFFFF, 16'd5,    1'b1, 2};
      vt[3] = '{16'd3,    16'd10,   16'd0,    16'd3,    1'b0, 17};
      vt[4] = '{16'd1234, 16'd1234, 16'd1,    16'd0,    1'b0, 17};
      vt[5] = '{16'd0,    16'd5,    16'd0,    16'd0,    1'b0, 17};
      vt[6] = '{16'hFFFF, 16'd1,    16'hFFFF, 16'd0,    1'b0, 17};
      vt[7] = '{16'd0,    16'd0,    16'hFFFF, 16'd0,    1'b1, 2};
`endif

      // Reset state
      reset = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_quotient", 64'(quotient), 64'd0);
      chk("reset_remainder", 64'(remainder), 64'd0);
      chk("reset_dbz", 64'(div_by_zero), 64'd0);
      reset = 1'b1;

      // Vector table
      for (int i = 0; i < 8; i++) begin
         pulse_start(vt[i].a, vt[i].b);
         chk("busy_after_start", 64'(busy), 64'd1);
         wait_done(lat, q, r, z, bcnt, bdone);
         chk($sformatf("vec%0d_quotient", i), 64'(q), 64'(vt[i].q));
         chk($sformatf("vec%0d_remainder", i), 64'(r), 64'(vt[i].r));
         chk($sformatf("vec%0d_dbz", i), 64'(z), 64'(vt[i].z));
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].lat));
         chk($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'(vt[i].lat - 1));
         chk($sformatf("vec%0d_busy_at_done", i), 64'(bdone), 64'd0);
         @(negedge clk);
         chk($sformatf("vec%0d_done_one_cycle", i), 64'(done), 64'd0);
      end

      // start while busy is ignored
      pulse_start(16'd50, 16'd3);
      repeat (4) @(negedge clk);
      start = 1'b1; dividend = 16'd9; divisor = 16'd9;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, q, r, z, bcnt, bdone);
      chk("ignore_quotient", 64'(q), 64'd16);
      chk("ignore_remainder", 64'(r), 64'd2);
      chk("ignore_seen", 64'(lat > 0), 64'd1);
      pulse_start(16'd1, 16'd0);
      wait_done(lat, q, r, z, bcnt, bdone);
      chk("after_ignore_quotient", 64'(q), 64'hFFFF);
      chk("after_ignore_remainder", 64'(r), 64'd1);
      chk("after_ignore_dbz", 64'(z), 64'd1);

      // reset in the middle of an operation
      pulse_start(16'd1000, 16'd10);
      repeat (7) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_quotient", 64'(quotient), 64'd0);
      chk("abort_remainder", 64'(remainder), 64'd0);
      chk("abort_dbz", 64'(div_by_zero), 64'd0);
      reset = 1'b1;
      ndone = 0;
      repeat (25) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("abort_no_done", 64'(ndone), 64'd0);
      pulse_start(16'd1000, 16'd10);
      wait_done(lat, q, r, z, bcnt, bdone);
      chk("fresh_quotient", 64'(q), 64'd100);
      chk("fresh_remainder", 64'(r), 64'd0);
      chk("fresh_latency", 64'(lat), 64'd17);

      // start held high retriggers every W+2 cycles
      @(negedge clk);
      start = 1'b1; dividend = 16'd20; divisor = 16'd6;
      for (int n = 0; n <= 40; n++) begin
         @(negedge clk);
         if (done) begin
            dpos.push_back(n);
            chk("retrig_quotient", 64'(quotient), 64'd3);
            chk("retrig_remainder", 64'(remainder), 64'd2);
         end
      end
      start = 1'b0;
      chk("retrig_count", 64'(dpos.size()), 64'd2);
      if (dpos.size() == 2) begin
         chk("retrig_first", 64'(dpos[0]), 64'd17);
         chk("retrig_second", 64'(dpos[1]), 64'd35);
      end
      repeat (20) @(negedge clk);

      // Randomized operations against the reference model
      for (int i = 0; i < 120; i++) begin
         int sel;
         sel = $urandom_range(0, 9);
         a = W'($urandom);
         if (sel == 0) b = '0;
         else if (sel < 4) b = W'($urandom_range(1, 15));
         else b = W'($urandom);
         exp_q.push_back(ref_div(a, b));
         pulse_start(a, b);
         wait_done(lat, q, r, z, bcnt, bdone);
         exp_v = exp_q.pop_front();
         chk($sformatf("rand%0d_%0h_%0h", i, a, b), 64'({z, q, r}), 64'(exp_v));
         chk($sformatf("rand%0d_latency", i), 64'(lat), (b == '0) ? 64'd2 : 64'd17);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
